// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 640x480@60 VGA timing constants
`timescale 1ns/1ps
package vga_pkg;

  // Horizontal line, in pixel clocks
  localparam logic [9:0] H_SYNC   = 10'd96;
  localparam logic [9:0] H_BP     = 10'd48;
  localparam logic [9:0] H_ACTIVE = 10'd640;
  localparam logic [9:0] H_FP     = 10'd16;
  localparam logic [9:0] H_TOTAL  = 10'd800;

  // Vertical frame, in lines
  localparam logic [9:0] V_SYNC   = 10'd2;
  localparam logic [9:0] V_BP     = 10'd33;
  localparam logic [9:0] V_ACTIVE = 10'd480;
  localparam logic [9:0] V_FP     = 10'd10;
  localparam logic [9:0] V_TOTAL  = 10'd525;

  // Active-area boundaries: start inclusive, end exclusive
  localparam logic [9:0] H_ACT_START = H_SYNC + H_BP;
  localparam logic [9:0] V_ACT_START = V_SYNC + V_BP;
  localparam logic [9:0] H_ACT_END   = H_ACT_START + H_ACTIVE;
  localparam logic [9:0] V_ACT_END   = V_ACT_START + V_ACTIVE;

  // Coordinate value driven when no pixel is being requested
  localparam logic [9:0] PIX_NONE = 10'h3FF;

endpackage

// File: rtl/vga_timing_ctrl.sv
// rtl/vga_timing_ctrl.sv - VGA raster timing with latency-compensated pixel fetch
`timescale 1ns/1ps
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int   DATA_LAT = 1,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        pix_data_req,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [15:0] rgb,
  output logic        frame_start
);

  // Requests lead the active area by DATA_LAT so the returned pixel lands
  // in the same register stage that raises de for that column.
  localparam logic [9:0] REQ_H_START = H_ACT_START - 10'(DATA_LAT);
  localparam logic [9:0] REQ_H_END   = H_ACT_END - 10'(DATA_LAT);

  logic [9:0]  r_cnt_h;
  logic [9:0]  r_cnt_v;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_de;
  logic [15:0] r_rgb;
  logic        r_frame_start;

  logic        w_h_last;
  logic        w_v_last;
  logic        w_active;
  logic        w_req;
  logic [9:0]  w_pix_x;
  logic [9:0]  w_pix_y;

  assign w_h_last = (r_cnt_h == H_TOTAL - 10'd1);
  assign w_v_last = (r_cnt_v == V_TOTAL - 10'd1);
  assign w_active = (r_cnt_h >= H_ACT_START) && (r_cnt_h < H_ACT_END) &&
                    (r_cnt_v >= V_ACT_START) && (r_cnt_v < V_ACT_END);

  // Request window and coordinates, decoded straight from the counters
  always_comb begin
    w_req   = (r_cnt_h >= REQ_H_START) && (r_cnt_h < REQ_H_END) &&
              (r_cnt_v >= V_ACT_START) && (r_cnt_v < V_ACT_END);
    w_pix_x = PIX_NONE;
    w_pix_y = PIX_NONE;
    if (w_req) begin
      w_pix_x = r_cnt_h - REQ_H_START;
      w_pix_y = r_cnt_v - V_ACT_START;
    end
  end

  // Horizontal/vertical raster counters; vertical steps at end of each line
  always_ff @(posedge vga_clk) begin
    if (!sys_rst_n) begin
      r_cnt_h <= '0;
      r_cnt_v <= '0;
    end else if (w_h_last) begin
      r_cnt_h <= '0;
      r_cnt_v <= w_v_last ? '0 : r_cnt_v + 10'd1;
    end else begin
      r_cnt_h <= r_cnt_h + 10'd1;
    end
  end

  // Registered display outputs, one cycle behind the counter state
  always_ff @(posedge vga_clk) begin
    if (!sys_rst_n) begin
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_de          <= 1'b0;
      r_rgb         <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_hsync       <= (r_cnt_h < H_SYNC) ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= (r_cnt_v < V_SYNC) ? SYNC_POL : ~SYNC_POL;
      r_de          <= w_active;
      r_rgb         <= w_active ? pix_data : 16'h0000;
      r_frame_start <= (r_cnt_h == '0) && (r_cnt_v == '0);
    end
  end

  assign pix_x        = w_pix_x;
  assign pix_y        = w_pix_y;
  assign pix_data_req = w_req;
  assign hsync        = r_hsync;
  assign vsync        = r_vsync;
  assign de           = r_de;
  assign rgb          = r_rgb;
  assign frame_start  = r_frame_start;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb/tb_vga_timing_ctrl.sv - directed bench for vga_timing_ctrl, two parameter sets in parallel
`timescale 1ns/1ps
module tb_vga_timing_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  logic [15:0] pix_data_a, pix_data_b;
  logic [9:0]  pix_x_a, pix_y_a, pix_x_b, pix_y_b;
  logic        req_a, req_b;
  logic        hsync_a, vsync_a, de_a, fs_a;
  logic        hsync_b, vsync_b, de_b, fs_b;
  logic [15:0] rgb_a, rgb_b;

  always #5 clk = ~clk;

  vga_timing_ctrl #(.DATA_LAT(1), .SYNC_POL(1'b0)) u_dut_a (
    .vga_clk(clk), .sys_rst_n(rst_n), .pix_data(pix_data_a),
    .pix_x(pix_x_a), .pix_y(pix_y_a), .pix_data_req(req_a),
    .hsync(hsync_a), .vsync(vsync_a), .de(de_a), .rgb(rgb_a), .frame_start(fs_a)
  );

  vga_timing_ctrl #(.DATA_LAT(3), .SYNC_POL(1'b1)) u_dut_b (
    .vga_clk(clk), .sys_rst_n(rst_n), .pix_data(pix_data_b),
    .pix_x(pix_x_b), .pix_y(pix_y_b), .pix_data_req(req_b),
    .hsync(hsync_b), .vsync(vsync_b), .de(de_b), .rgb(rgb_b), .frame_start(fs_b)
  );

  // Pixel source models: return {y[5:0],x} DATA_LAT cycles after the request
  logic [15:0]      pipe_a;
  logic [2:0][15:0] pipe_b;
  always @(posedge clk) begin
    pipe_a <= req_a ? {pix_y_a[5:0], pix_x_a} : 16'hBEEF;
    pipe_b <= {pipe_b[1:0], (req_b ? {pix_y_b[5:0], pix_x_b} : 16'hBEEF)};
  end
  assign pix_data_a = pipe_a;
  assign pix_data_b = pipe_b[2];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference raster model
  int          m_h = 0, m_v = 0, cyc = 0;
  logic        e_hs = 1'b0, e_vs = 1'b0, e_de = 1'b0, e_fs = 1'b0;
  logic [15:0] e_rgb = '0;

  // Window statistics
  int   hs_cnt_a, vs_cnt_b, fs_cnt, pol_mis, last_fall;
  int   first_h_a, first_h_b, first_x_a, first_y_a, last_x_a, last_h_a, req_cnt_a;
  logic prev_hs_a = 1'b1;
  logic track_line = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [20:0] exp_comb(int lat);
    logic       r;
    logic [9:0] x, y;
    r = (m_v >= 35) && (m_v < 515) && (m_h >= 144 - lat) && (m_h < 784 - lat);
    x = r ? 10'(m_h - (144 - lat)) : 10'h3FF;
    y = r ? 10'(m_v - 35) : 10'h3FF;
    return {r, x, y};
  endfunction

  function automatic logic [19:0] exp_reg(logic pol);
    return {(e_hs ? pol : ~pol), (e_vs ? pol : ~pol), e_de, e_rgb, e_fs};
  endfunction

  task automatic step();
    logic rst_s;
    rst_s = rst_n;
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_s) begin
      m_h = 0; m_v = 0;
      e_hs = 1'b0; e_vs = 1'b0; e_de = 1'b0; e_rgb = '0; e_fs = 1'b0;
    end else begin
      e_de  = (m_h >= 144) && (m_h < 784) && (m_v >= 35) && (m_v < 515);
      e_rgb = e_de ? {6'(m_v - 35), 10'(m_h - 144)} : 16'h0000;
      e_hs  = (m_h < 96);
      e_vs  = (m_v < 2);
      e_fs  = (m_h == 0) && (m_v == 0);
      if (m_h == 799) begin
        m_h = 0;
        m_v = (m_v == 524) ? 0 : m_v + 1;
      end else begin
        m_h++;
      end
    end
    chk("comb_a", 64'({req_a, pix_x_a, pix_y_a}), 64'(exp_comb(1)));
    chk("comb_b", 64'({req_b, pix_x_b, pix_y_b}), 64'(exp_comb(3)));
    chk("reg_a", 64'({hsync_a, vsync_a, de_a, rgb_a, fs_a}), 64'(exp_reg(1'b0)));
    chk("reg_b", 64'({hsync_b, vsync_b, de_b, rgb_b, fs_b}), 64'(exp_reg(1'b1)));
    // window statistics
    if (hsync_a == 1'b0) hs_cnt_a++;
    if (vsync_b == 1'b1) vs_cnt_b++;
    if (fs_a) fs_cnt++;
    if (hsync_b === hsync_a || vsync_b === vsync_a) pol_mis++;
    if (prev_hs_a && !hsync_a) begin
      if (last_fall >= 0) chk("hs_period", 64'(cyc - last_fall), 64'd800);
      last_fall = cyc;
    end
    prev_hs_a = hsync_a;
    if (track_line) begin
      if (req_a) begin
        if (first_h_a < 0) begin
          first_h_a = m_h; first_x_a = int'(pix_x_a); first_y_a = int'(pix_y_a);
        end
        last_x_a = int'(pix_x_a); last_h_a = m_h; req_cnt_a++;
      end
      if (req_b && first_h_b < 0) first_h_b = m_h;
    end
  endtask

  task automatic run_until(input int v, input int h, input int limit);
    int n;
    n = 0;
    while (!(m_v == v && m_h == h) && n < limit) begin
      step();
      n++;
    end
    chk("run_until_reached", 64'(n < limit), 64'd1);
  endtask

  task automatic clear_stats();
    hs_cnt_a = 0; vs_cnt_b = 0; fs_cnt = 0; last_fall = -1;
  endtask

  task automatic release_and_check_frame_start();
    rst_n = 1'b1;
    clear_stats();
    step();
    chk("fs_after_release_a", 64'(fs_a), 64'd1);
    chk("fs_after_release_b", 64'(fs_b), 64'd1);
    chk("hsync_after_release_a", 64'(hsync_a), 64'd0);
    chk("vsync_after_release_b", 64'(vsync_b), 64'd1);
    repeat (2399) step();
    chk("hsync_asserted_3_lines", 64'(hs_cnt_a), 64'd288);
    chk("vsync_asserted_cycles", 64'(vs_cnt_b), 64'd1600);
    chk("frame_start_pulses", 64'(fs_cnt), 64'd1);
  endtask

  initial begin
    pol_mis = 0; last_fall = -1;
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_hsync_a", 64'(hsync_a), 64'd1);
    chk("rst_vsync_a", 64'(vsync_a), 64'd1);
    chk("rst_hsync_b", 64'(hsync_b), 64'd0);
    chk("rst_de_a", 64'(de_a), 64'd0);
    chk("rst_rgb_a", 64'(rgb_a), 64'd0);
    chk("rst_fs_a", 64'(fs_a), 64'd0);

    release_and_check_frame_start();

    // first active request line
    run_until(35, 0, 30000);
    first_h_a = -1; first_h_b = -1; first_x_a = -1; first_y_a = -1;
    last_x_a = -1; last_h_a = -1; req_cnt_a = 0;
    track_line = 1'b1;
    repeat (799) step();
    track_line = 1'b0;
    chk("first_req_h_lat1", 64'(first_h_a), 64'd143);
    chk("first_req_x_lat1", 64'(first_x_a), 64'd0);
    chk("first_req_y_lat1", 64'(first_y_a), 64'd0);
    chk("first_req_h_lat3", 64'(first_h_b), 64'd141);
    chk("last_req_h_lat1", 64'(last_h_a), 64'd782);
    chk("last_req_x_lat1", 64'(last_x_a), 64'd639);
    chk("reqs_per_line", 64'(req_cnt_a), 64'd640);

    // mid-frame reset, held 5 cycles
    run_until(40, 400, 6000);
    rst_n = 1'b0;
    step();
    chk("midrst_de_a", 64'(de_a), 64'd0);
    chk("midrst_rgb_a", 64'(rgb_a), 64'd0);
    chk("midrst_hsync_a", 64'(hsync_a), 64'd1);
    chk("midrst_vsync_b", 64'(vsync_b), 64'd0);
    chk("midrst_req_a", 64'(req_a), 64'd0);
    chk("midrst_pix_x_a", 64'(pix_x_a), 64'h3FF);
    repeat (4) step();

    release_and_check_frame_start();
    run_until(37, 0, 30000);
    chk("sync_polarity_inverted", 64'(pol_mis), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
